conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  Upstream feeder for the 3x3 MAC stage. Takes one packed 3-row column of pixels and
//  4-bit weights per accepted beat and shifts it into a 3-column window. It presents
//  i_im1..9 / i_ker1..9 plus a valid strobe in the exact layout the MAC consumes.
//  Tracks frame (row-strip) boundaries so windows never straddle frames.
// PARAMETERS
//  PIX_W    8    pixel width per row lane
//  WGT_W    4    weight width per row lane
//  IDX_W    16   width of window-index counter
// PORTS
//  clk          in   1        system clock
//  i_rst        in   1        synchronous, active-high reset
//  i_valid      in   1        input column valid
//  o_ready      out  1        column accepted when i_valid & o_ready; o_ready = ~i_stall
//  i_last       in   1        qualifies the final column of the current frame
//  i_img        in   3*PIX_W  row1=[PIX_W-1:0], row2 next lane, row3 top lane
//  i_wgt        in   3*WGT_W  same lane order as i_img
//  i_stall      in   1        downstream inhibit; freezes the block
//  o_im1..o_im9 out  PIX_W    window pixels; 1/4/7 oldest column, 3/6/9 newest
//  o_ker1..o_ker9 out WGT_W   window weights, same layout as pixels
//  o_valid      out  1        window valid (drives MAC i_valid)
//  o_win_idx    out  IDX_W    index of presented window within its frame, from 0
//  o_frame_done out  1        pulse with the last window of a frame
//  o_short      out  1        pulse: frame ended with fewer than 3 columns
// BEHAVIOUR
//  Reset: all window regs 0, o_valid 0, o_win_idx 0, o_frame_done 0, o_short 0,
//   col_cnt 0. Reset overrides i_stall. Mid-frame reset discards partial columns.
//  accept = i_valid & ~i_stall.
//  On accept: per row, shift oldest<-mid<-new.
//   Row1: im1<=im2, im2<=im3, im3<=lane1. Rows 2/3 use im4-6/im7-9. Weights identical.
//  col_cnt (2b) = columns held in the current frame, saturating at 3.
//   On accept: col_cnt <= i_last ? 0 : sat(col_cnt+1).
//  o_valid <= accept & (col_cnt >= 2). col_cnt is the pre-accept value.
//   Latency: 1 cycle from accepted column to window on outputs.
//  o_win_idx:
//   Increments on each cycle where o_valid is registered 1 and the frame continues.
//   Resets to 0 on the cycle after a window registered with i_last (the next
//   window starts at 0). Wraps modulo 2^IDX_W.
//  o_frame_done <= accept & i_last & (col_cnt >= 2).
//  o_short <= accept & i_last & (col_cnt < 2). No window is emitted for that frame.
//  Stall (i_stall=1, no reset): every register holds, including o_valid,
//   o_win_idx and the pulses, so a window stays stable until consumed.
//  No accept and no stall: o_valid, o_frame_done and o_short go to 0; window regs hold.
//  i_valid=0 mid-frame: bubbles allowed; col_cnt holds and the window resumes.
//  A frame of W>=3 columns yields exactly W-2 windows, indices 0..W-3.
//  i_last on the 3rd column: one window (idx 0) with o_frame_done=1.
// STRUCTURE
//  Shared package / include: PIX_W, WGT_W, and lane-slice macros for packed
//   3-row buses. These are shared with the MAC bench and packers.
//  Sub-module win_row_shift (3-deep shift, PIX_W+WGT_W wide, enable=accept):
//   instantiated 3x, one per row.
//  Top level: col_cnt, valid, index and pulse logic.
// TESTING
//  1 Reset: hold i_rst 3 cycles with i_valid=1 -> o_valid=0, all outputs 0, o_ready=1.
//  2 Stream: 6 columns, i_img lanes = {col,col+16,col+32}, i_last on col 5 ->
//     4 windows idx 0..3; window k has im1=k, im3=k+2, im9=k+34.
//     o_frame_done only with idx 3.
//  3 Back-to-back frames: two 4-col frames, no gap -> idx 0,1,0,1.
//     No window mixes columns across frames.
//  4 Stall: assert i_stall 5 cycles while o_valid=1 -> outputs frozen, o_ready=0.
//     Columns offered during the stall are not consumed. Release -> sequence resumes
//     with no loss or duplicate.
//  5 Short frame: 2 columns with i_last on the 2nd -> o_short=1 one cycle, o_valid never 1.
//     The next 3-col frame yields idx 0.
//  6 Bubbles and mid-frame reset: i_valid toggles 1010 -> windows match the dense case.
//     Reset after 2 columns, then 3 fresh columns -> one window of only the fresh data.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
// Shared widths, lane types and lane-slice helpers for packed 3-row buses.
// Used by the window generator, the MAC bench and the column packers.
package conv_window_gen_pkg;

  localparam int PIX_W = 8;
  localparam int WGT_W = 4;
  localparam int IDX_W = 16;
  localparam int ROWS  = 3;

  typedef logic [PIX_W-1:0]      pix_t;
  typedef logic [WGT_W-1:0]      wgt_t;
  typedef logic [ROWS*PIX_W-1:0] img_bus_t;
  typedef logic [ROWS*WGT_W-1:0] wgt_bus_t;
  typedef logic [IDX_W-1:0]      idx_t;

  typedef struct packed {
    wgt_t wgt;
    pix_t pix;
  } lane_t;

  // One row of the window: oldest, middle, newest column.
  typedef struct packed {
    lane_t old_c;
    lane_t mid_c;
    lane_t new_c;
  } row_win_t;

  // Row r lives in lane r; row 1 (r=0) is the low lane.
  function automatic pix_t img_lane(
    input img_bus_t b,
    input int       r
  );
    return b[r*PIX_W +: PIX_W];
  endfunction

  function automatic wgt_t wgt_lane(
    input wgt_bus_t b,
    input int       r
  );
    return b[r*WGT_W +: WGT_W];
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Column stream into the window generator: valid/ready plus frame tag.
// master drives i_valid/i_last/i_img/i_wgt, slave returns o_ready.
interface conv_window_gen_if;
  import conv_window_gen_pkg::*;

  logic     i_valid;
  logic     o_ready;
  logic     i_last;
  img_bus_t i_img;
  wgt_bus_t i_wgt;

  modport master (
    output i_valid,
    output i_last,
    output i_img,
    output i_wgt,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_last,
    input  i_img,
    input  i_wgt,
    output o_ready
  );

endinterface

// File: rtl/conv_window_gen_row.sv
// win_row_shift: 3-deep shift of pixel+weight lanes for one window row.
// Ports: clk, i_rst (sync), i_en (shift), i_d (new lane), o_win (3 columns).
module win_row_shift
  import conv_window_gen_pkg::*;
(
  input  logic     clk,
  input  logic     i_rst,
  input  logic     i_en,
  input  lane_t    i_d,
  output row_win_t o_win
);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_win <= '0;
    end else if (i_en) begin
      o_win.old_c <= o_win.mid_c;
      o_win.mid_c <= o_win.new_c;
      o_win.new_c <= i_d;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: builds 3x3 pixel/weight windows from a column stream.
// Ports: clk, i_rst, col (slave stream), i_stall, o_im1..9, o_ker1..9,
// o_valid, o_win_idx, o_frame_done, o_short.
module conv_window_gen
  import conv_window_gen_pkg::*;
(
  input  logic   clk,
  input  logic   i_rst,
  conv_window_gen_if.slave col,
  input  logic   i_stall,
  output pix_t   o_im1,
  output pix_t   o_im2,
  output pix_t   o_im3,
  output pix_t   o_im4,
  output pix_t   o_im5,
  output pix_t   o_im6,
  output pix_t   o_im7,
  output pix_t   o_im8,
  output pix_t   o_im9,
  output wgt_t   o_ker1,
  output wgt_t   o_ker2,
  output wgt_t   o_ker3,
  output wgt_t   o_ker4,
  output wgt_t   o_ker5,
  output wgt_t   o_ker6,
  output wgt_t   o_ker7,
  output wgt_t   o_ker8,
  output wgt_t   o_ker9,
  output logic   o_valid,
  output idx_t   o_win_idx,
  output logic   o_frame_done,
  output logic   o_short
);

  logic       accept;
  logic [1:0] col_cnt;
  logic       have_two;
  row_win_t   win [ROWS];

  assign col.o_ready = ~i_stall;
  assign accept      = col.i_valid & ~i_stall;
  assign have_two    = col_cnt[1];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    lane_t lane_d;

    assign lane_d.pix = img_lane(col.i_img, r);
    assign lane_d.wgt = wgt_lane(col.i_wgt, r);

    win_row_shift u_row (
      .clk   (clk),
      .i_rst (i_rst),
      .i_en  (accept),
      .i_d   (lane_d),
      .o_win (win[r])
    );
  end

  assign o_im1  = win[0].old_c.pix;
  assign o_im2  = win[0].mid_c.pix;
  assign o_im3  = win[0].new_c.pix;
  assign o_im4  = win[1].old_c.pix;
  assign o_im5  = win[1].mid_c.pix;
  assign o_im6  = win[1].new_c.pix;
  assign o_im7  = win[2].old_c.pix;
  assign o_im8  = win[2].mid_c.pix;
  assign o_im9  = win[2].new_c.pix;
  assign o_ker1 = win[0].old_c.wgt;
  assign o_ker2 = win[0].mid_c.wgt;
  assign o_ker3 = win[0].new_c.wgt;
  assign o_ker4 = win[1].old_c.wgt;
  assign o_ker5 = win[1].mid_c.wgt;
  assign o_ker6 = win[1].new_c.wgt;
  assign o_ker7 = win[2].old_c.wgt;
  assign o_ker8 = win[2].mid_c.wgt;
  assign o_ker9 = win[2].new_c.wgt;

  // A presented window is consumed on the first unstalled cycle;
  // the index then steps, or restarts if that window closed its frame.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      col_cnt      <= '0;
      o_valid      <= 1'b0;
      o_win_idx    <= '0;
      o_frame_done <= 1'b0;
      o_short      <= 1'b0;
    end else if (!i_stall) begin
      o_valid      <= accept & have_two;
      o_frame_done <= accept & col.i_last & have_two;
      o_short      <= accept & col.i_last & ~have_two;
      if (o_valid) begin
        o_win_idx <= o_frame_done ? '0 : o_win_idx + 1'b1;
      end
      if (accept) begin
        if (col.i_last)
          col_cnt <= 2'd0;
        else if (col_cnt != 2'd3)
          col_cnt <= col_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: reset, streaming, frames,
// stall, short frames, bubbles and mid-frame reset.
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  logic clk = 1'b0;
  logic i_rst;
  logic i_stall;

  always #5 clk = ~clk;

  conv_window_gen_if col_if ();

  pix_t o_im1, o_im2, o_im3, o_im4, o_im5;
  pix_t o_im6, o_im7, o_im8, o_im9;
  wgt_t o_ker1, o_ker2, o_ker3, o_ker4, o_ker5;
  wgt_t o_ker6, o_ker7, o_ker8, o_ker9;
  logic o_valid, o_frame_done, o_short;
  idx_t o_win_idx;

  conv_window_gen dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .col          (col_if),
    .i_stall      (i_stall),
    .o_im1        (o_im1),
    .o_im2        (o_im2),
    .o_im3        (o_im3),
    .o_im4        (o_im4),
    .o_im5        (o_im5),
    .o_im6        (o_im6),
    .o_im7        (o_im7),
    .o_im8        (o_im8),
    .o_im9        (o_im9),
    .o_ker1       (o_ker1),
    .o_ker2       (o_ker2),
    .o_ker3       (o_ker3),
    .o_ker4       (o_ker4),
    .o_ker5       (o_ker5),
    .o_ker6       (o_ker6),
    .o_ker7       (o_ker7),
    .o_ker8       (o_ker8),
    .o_ker9       (o_ker9),
    .o_valid      (o_valid),
    .o_win_idx    (o_win_idx),
    .o_frame_done (o_frame_done),
    .o_short      (o_short)
  );

  logic [71:0] got_pix;
  logic [35:0] got_ker;

  assign got_pix = {o_im9, o_im8, o_im7, o_im6, o_im5,
                    o_im4, o_im3, o_im2, o_im1};
  assign got_ker = {o_ker9, o_ker8, o_ker7, o_ker6, o_ker5,
                    o_ker4, o_ker3, o_ker2, o_ker1};

  int n_cmp = 0;
  int n_bad = 0;

  // Column c carries pixels c, c+16, c+32 on rows 1..3
  // and weights c, c+1, c+2 (mod 16).
  function automatic logic [71:0] exp_pix(input logic [7:0] n);
    logic [71:0] v;
    logic [7:0]  p;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = n - 8'd2 + 8'(c) + 8'(16 * r);
        v[(r*3+c)*8 +: 8] = p;
      end
    return v;
  endfunction

  function automatic logic [35:0] exp_ker(input logic [7:0] n);
    logic [35:0] v;
    logic [7:0]  p;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = n - 8'd2 + 8'(c) + 8'(r);
        v[(r*3+c)*4 +: 4] = p[3:0];
      end
    return v;
  endfunction

  task automatic drive_col(input logic [7:0] c, input logic last);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] w1;
    logic [7:0] w2;
    a  = c + 8'd16;
    b  = c + 8'd32;
    w1 = c + 8'd1;
    w2 = c + 8'd2;
    col_if.i_valid = 1'b1;
    col_if.i_last  = last;
    col_if.i_img   = {b, a, c};
    col_if.i_wgt   = {w2[3:0], w1[3:0], c[3:0]};
  endtask

  task automatic idle();
    col_if.i_valid = 1'b0;
    col_if.i_last  = 1'b0;
    col_if.i_img   = 24'hAAAAAA;
    col_if.i_wgt   = 12'h555;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_stall = 1'b0;
    drive_col(8'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_valid got %b exp 0", o_valid);
      end
      n_cmp++;
      if (got_pix !== '0 || got_ker !== '0) begin
        n_bad++;
        $display("FAIL reset_win got %h/%h exp 0", got_pix, got_ker);
      end
      n_cmp++;
      if ({o_win_idx, o_frame_done, o_short} !== '0) begin
        n_bad++;
        $display("FAIL reset_ctl idx %0d fd %b sh %b exp 0",
                 o_win_idx, o_frame_done, o_short);
      end
      n_cmp++;
      if (col_if.o_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_ready got %b exp 1", col_if.o_ready);
      end
    end
    i_rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_stream();
    for (int c = 0; c < 6; c++) begin
      drive_col(8'(c), c == 5);
      tick();
      n_cmp++;
      if (o_valid !== (c >= 2)) begin
        n_bad++;
        $display("FAIL stream_valid c=%0d got %b exp %b",
                 c, o_valid, c >= 2);
      end
      if (c >= 2) begin
        n_cmp++;
        if (o_win_idx !== idx_t'(c - 2)) begin
          n_bad++;
          $display("FAIL stream_idx c=%0d got %0d exp %0d",
                   c, o_win_idx, c - 2);
        end
        n_cmp++;
        if (got_pix !== exp_pix(8'(c)) || got_ker !== exp_ker(8'(c))) begin
          n_bad++;
          $display("FAIL stream_win c=%0d got %h/%h exp %h/%h",
                   c, got_pix, got_ker, exp_pix(8'(c)), exp_ker(8'(c)));
        end
        n_cmp++;
        if (o_frame_done !== (c == 5)) begin
          n_bad++;
          $display("FAIL stream_done c=%0d got %b exp %b",
                   c, o_frame_done, c == 5);
        end
      end
    end
    idle();
    tick();
    n_cmp++;
    if (o_valid !== 1'b0 || o_frame_done !== 1'b0 || o_win_idx !== '0) begin
      n_bad++;
      $display("FAIL stream_idle v %b fd %b idx %0d exp 0 0 0",
               o_valid, o_frame_done, o_win_idx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++) begin
        c = 8'(10 + 10 * f + k);
        drive_col(c, k == 3);
        tick();
        n_cmp++;
        if (o_valid !== (k >= 2)) begin
          n_bad++;
          $display("FAIL b2b_valid f=%0d k=%0d got %b exp %b",
                   f, k, o_valid, k >= 2);
        end
        n_cmp++;
        if (o_win_idx !== idx_t'(k >= 2 ? k - 2 : 0)) begin
          n_bad++;
          $display("FAIL b2b_idx f=%0d k=%0d got %0d exp %0d",
                   f, k, o_win_idx, k >= 2 ? k - 2 : 0);
        end
        if (k >= 2) begin
          n_cmp++;
          if (got_pix !== exp_pix(c) || o_frame_done !== (k == 3)) begin
            n_bad++;
            $display("FAIL b2b_win f=%0d k=%0d got %h fd %b exp %h fd %b",
                     f, k, got_pix, o_frame_done, exp_pix(c), k == 3);
          end
        end
      end
    idle();
    tick();
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      drive_col(8'(30 + k), 1'b0);
      tick();
    end
    n_cmp++;
    if (o_valid !== 1'b1 || got_pix !== exp_pix(8'd32)) begin
      n_bad++;
      $display("FAIL stall_pre v %b got %h exp 1 %h",
               o_valid, got_pix, exp_pix(8'd32));
    end
    i_stall = 1'b1;
    drive_col(8'd99, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (col_if.o_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_ready i=%0d got %b exp 0", i, col_if.o_ready);
      end
      n_cmp++;
      if (o_valid !== 1'b1 || o_win_idx !== '0 ||
          got_pix !== exp_pix(8'd32) || got_ker !== exp_ker(8'd32)) begin
        n_bad++;
        $display("FAIL stall_hold i=%0d v %b idx %0d got %h exp 1 0 %h",
                 i, o_valid, o_win_idx, got_pix, exp_pix(8'd32));
      end
    end
    i_stall = 1'b0;
    drive_col(8'd33, 1'b0);
    #1;
    n_cmp++;
    if (col_if.o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release_ready got %b exp 1", col_if.o_ready);
    end
    for (int k = 3; k < 6; k++) begin
      drive_col(8'(30 + k), k == 5);
      tick();
      n_cmp++;
      if (o_valid !== 1'b1 || o_win_idx !== idx_t'(k - 2) ||
          got_pix !== exp_pix(8'(30 + k)) ||
          o_frame_done !== (k == 5)) begin
        n_bad++;
        $display("FAIL stall_resume k=%0d v %b idx %0d fd %b got %h exp %0d %h",
                 k, o_valid, o_win_idx, o_frame_done, got_pix,
                 k - 2, exp_pix(8'(30 + k)));
      end
    end
    idle();
    tick();
  endtask

  task automatic test_short();
    drive_col(8'd40, 1'b0);
    tick();
    drive_col(8'd41, 1'b1);
    tick();
    n_cmp++;
    if (o_short !== 1'b1 || o_valid !== 1'b0 || o_frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL short_pulse sh %b v %b fd %b exp 1 0 0",
               o_short, o_valid, o_frame_done);
    end
    for (int k = 0; k < 3; k++) begin
      drive_col(8'(50 + k), k == 2);
      tick();
      n_cmp++;
      if (o_short !== 1'b0 || o_valid !== (k == 2)) begin
        n_bad++;
        $display("FAIL short_next k=%0d sh %b v %b exp 0 %b",
                 k, o_short, o_valid, k == 2);
      end
    end
    n_cmp++;
    if (o_win_idx !== '0 || o_frame_done !== 1'b1 ||
        got_pix !== exp_pix(8'd52)) begin
      n_bad++;
      $display("FAIL short_win idx %0d fd %b got %h exp 0 1 %h",
               o_win_idx, o_frame_done, got_pix, exp_pix(8'd52));
    end
    idle();
    tick();
  endtask

  task automatic test_bubbles_reset();
    for (int k = 0; k < 4; k++) begin
      drive_col(8'(60 + k), k == 3);
      tick();
      n_cmp++;
      if (o_valid !== (k >= 2) ||
          (k >= 2 && (o_win_idx !== idx_t'(k - 2) ||
                      got_pix !== exp_pix(8'(60 + k))))) begin
        n_bad++;
        $display("FAIL bubble_win k=%0d v %b idx %0d got %h exp %h",
                 k, o_valid, o_win_idx, got_pix, exp_pix(8'(60 + k)));
      end
      if (k < 3) begin
        idle();
        tick();
        n_cmp++;
        if (o_valid !== 1'b0 ||
            (k == 2 && got_pix !== exp_pix(8'd62))) begin
          n_bad++;
          $display("FAIL bubble_gap k=%0d v %b got %h exp 0", k, o_valid, got_pix);
        end
      end
    end
    idle();
    tick();
    drive_col(8'd70, 1'b0);
    tick();
    drive_col(8'd71, 1'b0);
    tick();
    idle();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_cmp++;
    if (got_pix !== '0 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_clear got %h v %b exp 0", got_pix, o_valid);
    end
    for (int k = 0; k < 3; k++) begin
      drive_col(8'(80 + k), k == 2);
      tick();
      n_cmp++;
      if (o_valid !== (k == 2)) begin
        n_bad++;
        $display("FAIL midrst_valid k=%0d got %b exp %b", k, o_valid, k == 2);
      end
    end
    n_cmp++;
    if (got_pix !== exp_pix(8'd82) || got_ker !== exp_ker(8'd82) ||
        o_win_idx !== '0 || o_frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_win got %h idx %0d fd %b exp %h 0 1",
               got_pix, o_win_idx, o_frame_done, exp_pix(8'd82));
    end
    idle();
    tick();
  endtask

  initial begin
    i_rst   = 1'b1;
    i_stall = 1'b0;
    idle();
    test_reset();
    test_stream();
    test_back_to_back();
    test_stall();
    test_short();
    test_bubbles_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
